// File: rtl/pcf8591_pkg.sv
// pcf8591_pkg: shared FSM encoding and arithmetic constants for the PCF8591 voltage display.
package pcf8591_pkg;
    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_MUL    = 2'd1;
    localparam logic [1:0] ST_DIV    = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;
    localparam logic [7:0] DIVISOR = 8'd255;
    localparam logic [19:0] ROUND = 20'd127;
    localparam logic [5:0] POINT_MASK = 6'b001000;
endpackage

// File: rtl/pcf8591_div20.sv
// pcf8591_div20: 20-bit by 8-bit restoring divider, one quotient bit per cycle.
module pcf8591_div20 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [19:0] dividend_i,
    input  logic [7:0]  divisor_i,
    output logic        done_o,
    output logic [19:0] quotient_o
);
    logic [19:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic [4:0] cnt_q;
    logic busy_q;
    logic [8:0] shifted, trial;
    // trial[8] set means the trial subtraction borrowed, so the remainder is restored
    always_comb begin
        shifted = {rem_q, quo_q[19]};
        trial = shifted - {1'b0, divisor_i};
        rem_d = trial[8] ? shifted[7:0] : trial[7:0];
        quo_d = {quo_q[18:0], ~trial[8]};
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + 5'd1;
            busy_q <= cnt_q != 5'd19;
        end
    end
    assign done_o = busy_q && cnt_q == 5'd19;
    assign quotient_o = quo_q;
endmodule

// File: rtl/pcf8591_volt_disp.sv
// pcf8591_volt_disp: averages PCF8591 samples and converts them to millivolts for a 6-digit display.
module pcf8591_volt_disp
    import pcf8591_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int VREF_MV = 3300
) (
    input  logic        clk_pcf8591,
    input  logic        rst_n,
    input  logic [7:0]  ad_data,
    input  logic        ad_valid,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        en,
    output logic        sign,
    output logic        upd
);
    logic [1:0] state_q, state_d;
    logic [11:0] acc_q, acc_d, sum;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] avg_q, avg_d;
    logic [19:0] prod_q, prod_d, mul_term;
    logic [2:0] mcnt_q, mcnt_d;
    logic [19:0] data_q, data_d, quotient;
    logic upd_q, upd_d, en_q, en_d;
    logic div_start, div_done, last;
    assign sum = acc_q + {4'b0, ad_data};
    assign last = cnt_q == 5'((1 << AVG_LOG2) - 1);
    assign mul_term = avg_q[mcnt_q] ? (20'(VREF_MV) << mcnt_q) : '0;
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        prod_d = prod_q;
        mcnt_d = mcnt_q;
        data_d = data_q;
        upd_d = 1'b0;
        en_d = en_q;
        div_start = 1'b0;
        case (state_q)
            ST_ACCUM: if (ad_valid) begin
                acc_d = last ? '0 : sum;
                cnt_d = last ? '0 : cnt_q + 5'd1;
                if (last) begin
                    avg_d = 8'(sum >> AVG_LOG2);
                    prod_d = '0;
                    mcnt_d = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                prod_d = prod_q + mul_term;
                mcnt_d = mcnt_q + 3'd1;
                div_start = mcnt_q == 3'd7;
                state_d = div_start ? ST_DIV : ST_MUL;
            end
            ST_DIV: state_d = div_done ? ST_UPDATE : ST_DIV;
            default: begin
                data_d = quotient;
                upd_d = 1'b1;
                en_d = 1'b1;
                state_d = ST_ACCUM;
            end
        endcase
    end
    // the divider loads on the last multiply edge so its 20 steps fit exactly in DIV
    pcf8591_div20 u_div (
        .clk_i(clk_pcf8591),
        .rst_ni(rst_n),
        .start_i(div_start),
        .dividend_i(prod_d + ROUND),
        .divisor_i(DIVISOR),
        .done_o(div_done),
        .quotient_o(quotient)
    );
    always_ff @(posedge clk_pcf8591 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
            prod_q <= '0;
            mcnt_q <= '0;
            data_q <= '0;
            upd_q <= 1'b0;
            en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
            prod_q <= prod_d;
            mcnt_q <= mcnt_d;
            data_q <= data_d;
            upd_q <= upd_d;
            en_q <= en_d;
        end
    end
    assign data = data_q;
    assign upd = upd_q;
    assign en = en_q;
    assign point = POINT_MASK;
    assign sign = 1'b0;
endmodule

// File: tb/tb_pcf8591_volt_disp.sv
// tb_pcf8591_volt_disp: directed scoreboard bench for the averaging millivolt converter.
module tb_pcf8591_volt_disp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] ad_data0 = '0, ad_data1 = '0;
    logic ad_valid0 = 1'b0, ad_valid1 = 1'b0;
    logic [19:0] data0, data1;
    logic [5:0] point0, point1;
    logic en0, en1, sign0, sign1, upd0, upd1;
    int tests = 0, fails = 0, cyc = 0, last_acc = 0, saved, hits;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pcf8591_volt_disp #(.AVG_LOG2(3), .VREF_MV(3300)) u0 (
        .clk_pcf8591(clk), .rst_n(rst_n), .ad_data(ad_data0), .ad_valid(ad_valid0),
        .data(data0), .point(point0), .en(en0), .sign(sign0), .upd(upd0)
    );
    pcf8591_volt_disp #(.AVG_LOG2(0), .VREF_MV(3300)) u1 (
        .clk_pcf8591(clk), .rst_n(rst_n), .ad_data(ad_data1), .ad_valid(ad_valid1),
        .data(data1), .point(point1), .en(en1), .sign(sign1), .upd(upd1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] model(input int sum, input int lg);
        return 20'((((sum >> lg) * 3300) + 127) / 255);
    endfunction

    task automatic send(input bit w, input logic [7:0] v);
        @(negedge clk);
        if (w) begin ad_data1 = v; ad_valid1 = 1'b1; end
        else begin ad_data0 = v; ad_valid0 = 1'b1; end
        @(posedge clk);
        #1;
        ad_valid0 = 1'b0;
        ad_valid1 = 1'b0;
        last_acc = cyc;
    endtask

    task automatic window_send(input bit w, input int n, input logic [7:0] a, input logic [7:0] b,
                               input int lg, input bit push);
        int sum = 0;
        for (int i = 0; i < n; i++) begin
            send(w, (i % 2 != 0) ? b : a);
            sum += int'((i % 2 != 0) ? b : a);
        end
        if (push) exp_q.push_back(model(sum, lg));
    endtask

    task automatic window_check(input bit w, input string tag);
        logic [19:0] exp;
        int lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (w ? upd1 : upd0) lat = cyc - last_acc;
        end
        check({tag, "_latency"}, lat, 29);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hfffff;
        check({tag, "_data"}, w ? data1 : data0, exp);
        check({tag, "_en"}, w ? en1 : en0, 1);
        @(posedge clk);
        #1;
        check({tag, "_upd_low"}, w ? upd1 : upd0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data0, 0);
        check("rst_en", en0, 0);
        check("rst_upd", upd0, 0);
        check("rst_point", point0, 6'b001000);
        check("rst_sign", sign0, 0);
        check("rst_data_avg0", data1, 0);
        check("rst_en_avg0", en1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        window_send(0, 8, 8'd255, 8'd255, 3, 1);
        window_check(0, "full_scale");
        repeat (5) @(posedge clk);
        #1;
        check("hold_data", data0, 3300);
        check("hold_upd", upd0, 0);
        check("point_run", point0, 6'b001000);
        check("sign_run", sign0, 0);

        window_send(0, 8, 8'd0, 8'd0, 3, 1);
        window_check(0, "zero");

        window_send(0, 8, 8'd128, 8'd128, 3, 1);
        window_check(0, "mid_128");

        window_send(0, 8, 8'd100, 8'd101, 3, 1);
        window_check(0, "alt_100_101");

        window_send(0, 8, 8'd128, 8'd128, 3, 1);
        repeat (14) @(posedge clk);
        saved = last_acc;
        send(0, 8'd255);
        last_acc = saved;
        window_check(0, "div_busy");
        window_send(0, 8, 8'd0, 8'd0, 3, 1);
        window_check(0, "after_drop");

        window_send(0, 8, 8'd255, 8'd255, 3, 0);
        repeat (17) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_rst_data", data0, 0);
        check("abort_rst_en", en0, 0);
        check("abort_rst_upd", upd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            hits += int'(upd0);
        end
        check("abort_no_upd", hits, 0);
        check("abort_data", data0, 0);
        check("abort_en", en0, 0);
        window_send(0, 8, 8'd255, 8'd255, 3, 1);
        window_check(0, "post_abort");

        window_send(1, 1, 8'd77, 8'd77, 0, 1);
        window_check(1, "avg0_77");
        check("avg0_idle_other", upd0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pcf8591_volt_disp.md
PCF8591_VOLT_DISP -- requirements
Module: pcf8591_volt_disp

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, log2 of samples averaged per update (legal range 0..4).
REQ-002 SHALL have parameter VREF_MV, default 3300, ADC reference in millivolts (legal range 1..4095).
REQ-003 SHALL have port clk_pcf8591  input  1  clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ad_data  input  8  PCF8591 conversion result, qualified by ad_valid.
REQ-006 SHALL have port ad_valid  input  1  single-cycle strobe, ad_data valid.
REQ-007 SHALL have port data  output  20  millivolt value for the 6-digit display driver.
REQ-008 SHALL have port point  output  6  decimal-point mask for the display driver.
REQ-009 SHALL have port en  output  1  display enable.
REQ-010 SHALL have port sign  output  1  minus-sign request.
REQ-011 SHALL have port upd  output  1  one-cycle pulse when data is refreshed.

Function
REQ-012 SHALL use the FSM states ACCUM, MUL, DIV and UPDATE, with ACCUM as the reset state.
REQ-013 In ACCUM, each ad_valid SHALL add ad_data to a 12-bit accumulator and increment the sample counter.
REQ-014 On the ad_valid that brings the counter to 2^AVG_LOG2, SHALL take avg = (acc + that sample) >> AVG_LOG2 (8 bits), clear acc and counter, and go to MUL.
REQ-015 MUL SHALL compute avg*VREF_MV with a shift-add multiplier: 8 cycles exactly, 1 bit per cycle, 20-bit product, then go to DIV.
REQ-016 DIV SHALL compute (product + 127) / 255 with a restoring divider: 20 cycles exactly, then go to UPDATE.
REQ-017 Result arithmetic: the quotient is truncated, the maximum is VREF_MV, and no intermediate value SHALL exceed 20 bits.
REQ-018 UPDATE SHALL, for 1 cycle:
- register the quotient into data;
- pulse upd high;
- set en to 1;
- return to ACCUM.
REQ-019 Latency: data and upd SHALL change on the 29th clock edge after the edge that accepted the final sample of a window.
REQ-020 ad_valid asserted in MUL, DIV or UPDATE SHALL be dropped, with no effect on acc, counter or the next window.
REQ-021 point SHALL be constant 6'b001000, so the value displays as x.xxx V.
REQ-022 sign SHALL be constant 0.
REQ-023 data SHALL hold its value between updates.
REQ-024 en, once set, SHALL stay 1 until reset.
REQ-025 When AVG_LOG2 = 0, every accepted sample SHALL start a conversion.

Reset
REQ-026 While rst_n is low, outputs SHALL be: data = 0, en = 0, upd = 0, point = 6'b001000, sign = 0.
REQ-027 While rst_n is low, internal state SHALL be: acc = 0, counter = 0, FSM = ACCUM, multiplier and divider registers = 0.
REQ-028 Reset asserted mid-MUL or mid-DIV SHALL abort the conversion without updating data, and the first window after release SHALL start from an empty accumulator.

Structure
REQ-029 The state encoding, the DIVISOR = 255 and ROUND = 127 constants, and the fixed POINT_MASK SHALL live in the shared pcf8591 package.
REQ-030 The restoring divider SHALL be the sub-module pcf8591_div20, with start/done handshake, 20-bit dividend, 8-bit divisor and 20-bit quotient.
REQ-031 The multiplier SHALL stay inline in the top block.

Verification
REQ-032 Bench SHALL cover: 8 samples of 255 -> data = 3300, upd pulses 29 edges after the 8th sample, en = 1.
REQ-033 Bench SHALL cover: 8 samples of 0 -> data = 0, upd pulses, en = 1.
REQ-034 Bench SHALL cover: 8 samples of 128 -> data = 1656; alternating 100/101 -> avg 100, data = 1294.
REQ-035 Bench SHALL cover: ad_valid of 255 during DIV, then 8 samples of 0 -> the extra sample is dropped and data = 0.
REQ-036 Bench SHALL cover: rst_n pulsed low at DIV cycle 10 -> data stays 0, en = 0, no upd; then 8 samples of 255 -> data = 3300.
REQ-037 Bench SHALL cover: AVG_LOG2 = 0 with a single sample of 77 -> data = 996 after 29 edges.
